// File: rtl/zfsoc_pio_pkg.sv
// Shared constants for the zfsoc PIO blocks: Avalon word addresses and bus width.
package zfsoc_pio_pkg;

  localparam int AV_DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/zfsoc_debounce.sv
// Single-bit debounce filter: dout follows din only after CYCLES consecutive
// samples that differ from the current dout.
module zfsoc_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/zfsoc_key_pio.sv
// Avalon-MM input PIO: synchronised inputs, sticky edge capture, maskable level irq.
// Define ZFSOC_KEY_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module zfsoc_key_pio
  import zfsoc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int CAPTURE_FALLING = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [AV_DATA_W-1:0] writedata,
  output logic [AV_DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  // Avalon slave: a write is taken on the clock edge where chipselect & ~write_n;
  // readdata is a pure function of address and registers (no waitrequest, latency 0).
  logic [WIDTH-1:0] sync1, sync2, filt, prev;
  logic [WIDTH-1:0] mask, cap, edge_det, clr;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef ZFSOC_KEY_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    zfsoc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (sync2[i]),
      .dout (filt[i])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filt = sync2;
`endif

  if (CAPTURE_FALLING != 0) begin : g_fall
    assign edge_det = prev & ~filt;
  end else begin : g_rise
    assign edge_det = ~prev & filt;
  end

  assign clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // A new edge on the same clock as a W1C keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      cap  <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) mask <= writedata[WIDTH-1:0];
      cap <= edge_det | (cap & ~clr);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = filt;
      ADDR_DIR:     readdata = '0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(cap & mask);

  if (WIDTH < AV_DATA_W) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[AV_DATA_W-1:WIDTH];
  end

endmodule

// File: tb/tb_zfsoc_key_pio.sv
// Self-checking bench for zfsoc_key_pio: directed vector table, hand-written
// corner sequences and randomized traffic against a delay-line reference model.
module tb_zfsoc_key_pio;

  localparam int W  = 4;
  localparam int DB = 8;
`ifdef ZFSOC_KEY_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  in_val;
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  zfsoc_key_pio #(.WIDTH(W), .CAPTURE_FALLING(1), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [1:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    exp_q.push_back(exp);
    check(name, readdata, exp_q.pop_front());
  endtask

  task automatic irq_check(input string name, input bit exp);
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  function automatic vec_t mk(input logic [3:0] in_val, input bit wr, input logic [1:0] waddr,
                              input logic [31:0] wdata, input logic [1:0] raddr,
                              input logic [31:0] exp_rd, input bit exp_irq);
    vec_t v;
    v.in_val = in_val; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.raddr = raddr; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  // reset test: capture everything, then reset between edges
  task automatic reset_test();
    in_port = '1;
    repeat (LAT + 2) tick();
    drive_write(2'd2, 32'hF);
    in_port = '0;
    repeat (LAT + 1) tick();
    read_check("rst_pre_cap", 2'd3, 32'hF);
    irq_check("rst_pre_irq", 1'b1);
    reset = 1'b1;
    #1;
    irq_check("rst_irq", 1'b0);
    for (int a = 0; a < 4; a++) read_check($sformatf("rst_rd%0d", a), 2'(a), 32'h0);
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifndef ZFSOC_KEY_DEBOUNCE_EN
  task automatic table_test();
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd0, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd0, 32'hA, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd1, 32'h0, 0));
    vecs.push_back(mk(4'hA, 1, 2'd1, 32'hFFFFFFFF, 2'd0, 32'hA, 0));
    vecs.push_back(mk(4'hA, 1, 2'd0, 32'hFFFFFFFF, 2'd0, 32'hA, 0));
    vecs.push_back(mk(4'hA, 1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd2, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'hA, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hF, 1, 2'd2, 32'hFFFFFFF1, 2'd2, 32'h1, 0));
    vecs.push_back(mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hE, 0, 2'd0, 32'h0,        2'd0, 32'hE, 0));
    vecs.push_back(mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h1, 1));
    vecs.push_back(mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h4, 0));
    vecs.push_back(mk(4'hA, 1, 2'd2, 32'h4,        2'd3, 32'h4, 1));
    vecs.push_back(mk(4'hA, 1, 2'd2, 32'h0,        2'd3, 32'h4, 0));
    vecs.push_back(mk(4'hA, 1, 2'd3, 32'hF,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h1, 0));
    vecs.push_back(mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h0, 0));
    vecs.push_back(mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'hE, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].wr) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = vecs[i].waddr;
        writedata  = vecs[i].wdata;
      end
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
      irq_check($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end
  endtask

  task automatic glitch_test();
    in_port = 4'hF;
    repeat (4) tick();
    in_port = 4'hE;
    tick();
    tick();
    read_check("glitch_data", 2'd0, 32'hE);
    tick();
    read_check("glitch_cap", 2'd3, 32'h1);
    tick();
    tick();
    in_port = 4'hF;
    repeat (4) tick();
    drive_write(2'd3, 32'h1);
    read_check("glitch_clr", 2'd3, 32'h0);
  endtask

  // reference model: in_port history per clock edge; DATA is the value from
  // one edge back, and a capture fires when the history shows a 1->0 step
  task automatic random_test();
    logic [3:0]  hist[$];
    logic [3:0]  mask_m, cap_m, in_v, fall, clr;
    logic [31:0] wd, exp;
    int          op, sz;
    logic [1:0]  ra;
    reset = 1'b1;
    in_port = '0;
    tick();
    reset = 1'b0;
    hist = '{4'h0, 4'h0, 4'h0};
    mask_m = '0;
    cap_m = '0;
    for (int n = 0; n < 400; n++) begin
      in_v = 4'($urandom_range(0, 15));
      op   = $urandom_range(0, 9);
      wd   = $urandom();
      ra   = 2'($urandom_range(0, 3));
      in_port = in_v;
      if (op >= 8) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = (op == 8) ? 2'd2 : 2'd3;
        writedata  = wd;
      end
      sz   = hist.size();
      fall = hist[sz-3] & ~hist[sz-2];
      clr  = (op == 9) ? wd[3:0] : 4'h0;
      cap_m = fall | (cap_m & ~clr);
      if (op == 8) mask_m = wd[3:0];
      hist.push_back(in_v);
      if (hist.size() > 4) void'(hist.pop_front());
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      sz = hist.size();
      case (ra)
        2'd0:    exp = {28'h0, hist[sz-2]};
        2'd2:    exp = {28'h0, mask_m};
        2'd3:    exp = {28'h0, cap_m};
        default: exp = 32'h0;
      endcase
      read_check("rand_rd", ra, exp);
      irq_check("rand_irq", |(cap_m & mask_m));
    end
  endtask
`else
  task automatic debounce_test();
    in_port = 4'hF;
    repeat (20) tick();
    read_check("db_idle", 2'd0, 32'hF);
    in_port = 4'hE;
    repeat (5) tick();
    in_port = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      read_check("db_glitch_data", 2'd0, 32'hF);
      read_check("db_glitch_cap", 2'd3, 32'h0);
    end
    in_port = 4'hE;
    for (int k = 1; k <= 12; k++) begin
      tick();
      read_check($sformatf("db_pulse_data%0d", k), 2'd0, (k >= 10) ? 32'hE : 32'hF);
      read_check($sformatf("db_pulse_cap%0d", k), 2'd3, (k >= 11) ? 32'h1 : 32'h0);
    end
    in_port = 4'hF;
    repeat (20) tick();
    read_check("db_after", 2'd0, 32'hF);
    read_check("db_sticky", 2'd3, 32'h1);
  endtask
`endif

  // main sequence and final report
  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) tick();
    reset = 1'b0;
    reset_test();
`ifndef ZFSOC_KEY_DEBOUNCE_EN
    table_test();
    glitch_test();
    random_test();
`else
    debounce_test();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
